pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 256, width of the stage payload (aluop, alusel, operands, wd, wreg, link, delayslot, inst, pc, excepttype concatenated).
REQ-002 SHALL have parameter STAGE_IDX, default 2, index of this stage in the stall vector.
REQ-003 SHALL have parameter NOP_VALUE, default all-zero, bubble payload driven when empty.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous exception flush.
REQ-007 SHALL have port stall  input  6  pipeline stall vector from ctrl; 1 = Stop.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-010 SHALL have port in_payload  input  PAYLOAD_W  upstream payload.
REQ-011 SHALL have port out_valid  output  1  out_payload is a real instruction.
REQ-012 SHALL have port out_ready  input  1  downstream accepts payload.
REQ-013 SHALL have port out_payload  output  PAYLOAD_W  payload to next stage.
REQ-014 SHALL have port occupancy  output  2  entries held (0, 1, 2).
REQ-015 SHALL have port clr_stats  input  1  synchronous clear of bubble_cnt.
REQ-016 SHALL have port bubble_cnt  output  16  saturating count of bubbles issued.

Function
REQ-017 SHALL hold two registered entries, main and skid; states EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
REQ-018 SHALL define freeze_up = stall[STAGE_IDX]; freeze_dn = stall[STAGE_IDX+1].
REQ-019 SHALL drive in_ready = (state != FULL) && !freeze_up, combinationally from registered state and stall only, never from out_ready.
REQ-020 SHALL define in_fire = in_valid && in_ready; out_fire = out_valid && out_ready && !freeze_dn.
REQ-021 SHALL drive out_valid = (state != EMPTY); out_payload = main when valid, else NOP_VALUE.
REQ-022 SHALL transition EMPTY: in_fire -> ONE, main <= in_payload.
REQ-023 SHALL transition ONE: in_fire && out_fire -> ONE, main <= in_payload; in_fire only -> FULL, skid <= in_payload; out_fire only -> EMPTY.
REQ-024 SHALL transition FULL: out_fire -> ONE, main <= skid; otherwise hold.
REQ-025 SHALL give latency of 1 cycle from in_fire to out_valid when EMPTY; order SHALL be strictly FIFO.
REQ-026 SHALL, when freeze_up && !freeze_dn, accept nothing and let downstream drain, so NOP_VALUE bubbles appear once empty.
REQ-027 SHALL, when freeze_dn, hold all entries and out_payload unchanged.
REQ-028 SHALL give flush priority over all events: on flush, next state EMPTY, main and skid <= NOP_VALUE, and concurrent in_fire/out_fire are discarded.
REQ-029 SHALL increment bubble_cnt on each cycle with !out_valid && !freeze_dn && !flush, saturating at 0xFFFF.
REQ-030 SHALL clear bubble_cnt on clr_stats; clear SHALL win over a simultaneous increment.

Reset
REQ-031 SHALL, while rst = 0, force state EMPTY, main = skid = NOP_VALUE, bubble_cnt = 0, out_valid = 0, occupancy = 0; in_ready follows REQ-019.
REQ-032 SHALL abandon any held entries when reset asserts mid-operation; no payload SHALL survive reset.

Structure
REQ-033 SHALL take Stop/NoStop, stall-vector width 6, and the occupancy state encoding from the shared pipe_pkg package.
REQ-034 SHALL be a single flat module; no sub-module is warranted.
REQ-035 SHALL be elaboration-checked: STAGE_IDX in 0..4, PAYLOAD_W >= 1.

Verification
REQ-036 SHALL cover: after reset, in_payload = 0xA5 with in_valid, out_ready = 1 -> out_payload = 0xA5, out_valid = 1 next cycle, occupancy = 1.
REQ-037 SHALL cover: out_ready = 0 for 2 cycles, 3 inputs 0x1/0x2/0x3 -> occupancy = 2, in_ready = 0, 0x3 held upstream; release -> outputs 0x1, 0x2, 0x3 in order.
REQ-038 SHALL cover: stall = 6'b000100, STAGE_IDX = 2, occupancy = 1 -> entry drains, then out_payload = NOP_VALUE, bubble_cnt increments by 1 per cycle.
REQ-039 SHALL cover: FULL with in_fire pending and flush = 1 -> next cycle occupancy = 0, out_valid = 0, payloads = NOP_VALUE.
REQ-040 SHALL cover: bubble_cnt preloaded to 0xFFFE by idling -> saturates at 0xFFFF; clr_stats together with an increment -> 0.
REQ-041 SHALL cover: rst deasserted-then-asserted while FULL -> outputs are reset values within the same cycle, before any clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall-vector encoding and stage-buffer occupancy states.
package pipe_pkg;

    localparam int unsigned StallW = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Encoding doubles as the occupancy count driven on the port.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) pipeline stage buffer with stall-vector freeze, flush and bubble stats.
// in_ready depends only on registered state and stall, so it never combinationally follows out_ready.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W = 256,
    parameter int unsigned          STAGE_IDX = 2,
    parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [StallW-1:0]    stall,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    input  logic                 clr_stats,
    output logic [15:0]          bubble_cnt
);

    if (STAGE_IDX > 4 || PAYLOAD_W < 1) begin : gen_param_check
        $error("pipe_stage_buf: STAGE_IDX must be 0..4 and PAYLOAD_W >= 1");
    end

    occ_e                 state_q;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [15:0]          bubble_q;

    logic freeze_up;
    logic freeze_dn;
    logic in_fire;
    logic out_fire;
    logic unused_stall;

    assign freeze_up    = (stall[STAGE_IDX] == Stop);
    assign freeze_dn    = (stall[STAGE_IDX+1] == Stop);
    assign unused_stall = ^stall;

    assign in_ready    = (state_q != StFull) && !freeze_up;
    assign out_valid   = (state_q != StEmpty);
    assign out_payload = out_valid ? main_q : NOP_VALUE;
    assign occupancy   = state_q;
    assign bubble_cnt  = bubble_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready && !freeze_dn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else if (flush) begin
            state_q <= StEmpty;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q <= StOne;
                        main_q  <= in_payload;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_payload;
                    end else if (in_fire) begin
                        state_q <= StFull;
                        skid_q  <= in_payload;
                    end else if (out_fire) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
        end else if (clr_stats) begin
            bubble_q <= '0;
        end else if (!out_valid && !freeze_dn && !flush && (bubble_q != 16'hFFFF)) begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboarded bench for pipe_stage_buf: accepted payloads queue up, a monitor checks drain order.
module tb_pipe_stage_buf;

    localparam int unsigned PW  = 16;
    localparam int unsigned SI  = 2;
    localparam logic [PW-1:0] NOP = 16'h0BAD;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [5:0]    stall;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [1:0]    occupancy;
    logic          clr_stats;
    logic [15:0]   bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .PAYLOAD_W (PW),
        .STAGE_IDX (SI),
        .NOP_VALUE (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall       (stall),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .occupancy   (occupancy),
        .clr_stats   (clr_stats),
        .bubble_cnt  (bubble_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs change only at posedge+1, so values seen here are stable pre-edge.
    always @(posedge clk) begin
        if (!rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && !stall[SI+1]) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_out", {16'h0, out_payload}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_order", {16'h0, out_payload}, {16'h0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_payload);
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; stall = '0; in_valid = 1'b0; in_payload = '0;
        out_ready = 1'b1; clr_stats = 1'b0;
        step(); step();
        check("rst_occ", occupancy, 2'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_payload", out_payload, NOP);
        check("rst_bubble", bubble_cnt, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        step();

        // Single transfer, one-cycle latency
        in_valid = 1'b1; in_payload = 16'h00A5;
        step();
        in_valid = 1'b0;
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_payload", out_payload, 16'h00A5);
        check("t1_occ", occupancy, 2'd1);
        step();
        check("t1_drained", occupancy, 2'd0);

        // Backpressure fills skid; third word held upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = 16'h0001;
        step();
        in_payload = 16'h0002;
        step();
        check("t2_occ_full", occupancy, 2'd2);
        check("t2_in_ready_full", in_ready, 1'b0);
        in_payload = 16'h0003;
        step();
        check("t2_held_occ", occupancy, 2'd2);
        check("t2_held_head", out_payload, 16'h0001);
        out_ready = 1'b1;
        step();
        check("t2_second", out_payload, 16'h0002);
        check("t2_occ_one", occupancy, 2'd1);
        step();
        in_valid = 1'b0;
        check("t2_third", out_payload, 16'h0003);
        step();
        check("t2_empty", occupancy, 2'd0);

        // Upstream freeze: entry drains, then NOP bubbles counted
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 16'h0055;
        step();
        stall = 6'b000100; out_ready = 1'b1; in_payload = 16'h0066;
        step();
        check("t3_occ_drained", occupancy, 2'd0);
        check("t3_nop", out_payload, NOP);
        check("t3_in_ready", in_ready, 1'b0);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("t3_bubble0", bubble_cnt, 16'd0);
        step();
        check("t3_bubble1", bubble_cnt, 16'd1);
        step();
        check("t3_bubble2", bubble_cnt, 16'd2);
        check("t3_nop_still", out_payload, NOP);
        in_valid = 1'b0; stall = '0;

        // Downstream freeze holds the entry and the bubble count
        in_valid = 1'b1; in_payload = 16'h0077;
        step();
        in_valid = 1'b0; stall = 6'b001000; clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        step(); step();
        check("t4_hold_occ", occupancy, 2'd1);
        check("t4_hold_payload", out_payload, 16'h0077);
        check("t4_hold_bubble", bubble_cnt, 16'd0);
        stall = '0;
        step();
        check("t4_released", occupancy, 2'd0);

        // Flush from FULL with input pending
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 16'h0011;
        step();
        in_payload = 16'h0022;
        step();
        in_payload = 16'h0033; flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t5_flush_occ", occupancy, 2'd0);
        check("t5_flush_valid", out_valid, 1'b0);
        check("t5_flush_payload", out_payload, NOP);
        // Flush in ONE discards a concurrent in_fire
        in_valid = 1'b1; in_payload = 16'h0044; out_ready = 1'b0;
        step();
        in_payload = 16'h0045; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("t5_flush_one_occ", occupancy, 2'd0);
        in_valid = 1'b1; in_payload = 16'h0046;
        step();
        in_valid = 1'b0;
        check("t5_post_flush", out_payload, 16'h0046);
        step();

        // Bubble counter saturation and clear priority
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        repeat (16'hFFFE) @(posedge clk);
        #1;
        check("t6_preload", bubble_cnt, 16'hFFFE);
        step();
        check("t6_sat", bubble_cnt, 16'hFFFF);
        step();
        check("t6_sat_hold", bubble_cnt, 16'hFFFF);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("t6_clr_wins", bubble_cnt, 16'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 16'h0088;
        step();
        in_payload = 16'h0099;
        step();
        in_valid = 1'b0;
        check("t7_pre_full", occupancy, 2'd2);
        rst = 1'b0;
        #1;
        check("t7_async_occ", occupancy, 2'd0);
        check("t7_async_valid", out_valid, 1'b0);
        check("t7_async_payload", out_payload, NOP);
        check("t7_async_bubble", bubble_cnt, 16'd0);
        step();
        rst = 1'b1; out_ready = 1'b1;
        step();
        check("t7_nothing_survives", out_valid, 1'b0);
        in_valid = 1'b1; in_payload = 16'h00C3;
        step();
        in_valid = 1'b0;
        check("t7_after_reset", out_payload, 16'h00C3);
        step(); step();

        check("sb_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
